lcm_unit: RTL and testbench
===========================

LCM_UNIT -- requirements
Module: lcm_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port clr, input, 1 bit: reset, synchronous, active-low (0 = reset).
REQ-003 SHALL have port in_valid, input, 1 bit: operand triple on x/y/g is valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept a triple.
REQ-005 SHALL have port x, input, 4 bits: first operand, the same value fed to the gcd stage's xin.
REQ-006 SHALL have port y, input, 4 bits: second operand, the same value fed to the gcd stage's yin.
REQ-007 SHALL have port g, input, 4 bits: the gcd stage's gcd_out result for (x,y).
REQ-008 SHALL have port out_valid, output, 1 bit: lcm/err are valid.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 SHALL have port lcm, output, 8 bits: unsigned least common multiple.
REQ-011 SHALL have port err, output, 1 bit: consistency error (see Configuration).

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE; a triple is accepted on an edge where in_valid&&in_ready, and x, y, g are registered.
REQ-014 SHALL, in MUL, compute a registered 8-bit product p = x*y (max 225, no overflow), then go to DIV, or to DONE with lcm=0 if x==0 or y==0 or g==0.
REQ-015 SHALL, in DIV, perform an 8-iteration restoring division p/g at one quotient bit per clock, MSB first, with a 3-bit iteration counter and a 5-bit partial remainder.
REQ-016 SHALL load the quotient into lcm and enter DONE after the 8th DIV cycle.
REQ-017 SHALL assert out_valid in DONE only; lcm and err SHALL be held stable while out_valid=1 and out_ready=0.
REQ-018 SHALL return to IDLE on the edge where out_valid&&out_ready.
REQ-019 SHALL give latency from the accept edge to out_valid high of 10 clocks on the normal path and 2 clocks on the zero path.
REQ-020 SHALL ignore x, y, g and in_valid outside IDLE; g==0 with nonzero x,y SHALL give lcm=0 and err=1 (both builds).
REQ-021 SHALL sustain a throughput of at most one result per 11 clocks, with no pipelining.

Reset
REQ-022 SHALL, on clr==0 at a clock edge, go to IDLE with in_ready=1, out_valid=0, lcm=0, err=0, and clear the counter, remainder and product registers.
REQ-023 SHALL, on a reset in MUL, DIV or DONE, drop the operation with no output; the first accept after reset SHALL proceed normally.

Configuration
REQ-024 SHALL use macro LCM_CHECK_EN; when it is defined, err=1 in DONE if the final DIV remainder is nonzero, which flags a g that is not a divisor of x*y.
REQ-025 SHALL, when LCM_CHECK_EN is undefined, tie err to 0 except for the g==0 case in REQ-020, and omit the remainder-check logic; lcm SHALL be identical in both builds.

Structure
REQ-026 SHALL place in shared package lcm_pkg: operand width 4, product width 8, and the state enum (IDLE, MUL, DIV, DONE).
REQ-027 SHALL contain one sub-module, lcm_div8, the sequential restoring divider with start/done, used by the DIV state.

Verification
REQ-028 SHALL check: x=3, y=6, g=3, out_ready=1 -> lcm=6, err=0, out_valid exactly 10 clocks after accept.
REQ-029 SHALL check: x=4, y=8, g=4 -> lcm=8; then x=15, y=14, g=1 -> lcm=210; in_ready=0 throughout each operation.
REQ-030 SHALL check: x=0, y=5, g=5 -> lcm=0 after 2 clocks, err=0.
REQ-031 SHALL check: result ready, out_ready held 0 for 5 clocks -> lcm/out_valid stable, in_ready=0; out_ready=1 -> IDLE on the next edge.
REQ-032 SHALL check: clr=0 in the 4th DIV cycle -> next edge out_valid=0, lcm=0, in_ready=1; then x=5, y=10, g=5 -> lcm=10.
REQ-033 SHALL check, with LCM_CHECK_EN defined: x=5, y=7, g=2 -> err=1 (remainder 1); without the macro, the same stimulus -> err=0 and lcm=17.

Source files
------------

// File: rtl/lcm_pkg.sv
// Shared widths and state encoding for the lcm_unit block.
// Build option LCM_CHECK_EN enables the divisibility check on the final remainder.
package lcm_pkg;

  localparam int OP_W    = 4;
  localparam int PROD_W  = 8;
  localparam int REM_W   = 5;
  localparam int TRIAL_W = REM_W + 1;
  localparam int CNT_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/lcm_unit_div8.sv
// lcm_div8: sequential restoring divider, 8 quotient bits MSB first, one bit per clock.
// Build option LCM_CHECK_EN exposes the final partial remainder.
module lcm_div8
  import lcm_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [PROD_W-1:0] dividend,
  input  logic [OP_W-1:0]   divisor,
  output logic              busy,
  output logic              last,
`ifdef LCM_CHECK_EN
  output logic [REM_W-1:0]  remainder_next,
`endif
  output logic [PROD_W-1:0] quotient_next
);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [PROD_W-1:0]  dvd_q, dvd_d;
  logic               busy_q, busy_d;

  logic [REM_W-1:0]   cur_rem;
  logic [PROD_W-1:0]  cur_dvd;
  logic [TRIAL_W-1:0] trial;
  logic [REM_W-1:0]   rem_n;
  logic [PROD_W-1:0]  dvd_n;
  logic               q_bit;

  // The start edge already performs the first iteration, so eight edges yield eight bits.
  always_comb begin
    cur_rem = start ? '0 : rem_q;
    cur_dvd = start ? dividend : dvd_q;
    trial   = {cur_rem, cur_dvd[PROD_W-1]};
    if (trial >= TRIAL_W'(divisor)) begin
      rem_n = REM_W'(trial - TRIAL_W'(divisor));
      q_bit = 1'b1;
    end else begin
      rem_n = trial[REM_W-1:0];
      q_bit = 1'b0;
    end
    dvd_n = {cur_dvd[PROD_W-2:0], q_bit};

    rem_d  = rem_q;
    dvd_d  = dvd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      rem_d  = rem_n;
      dvd_d  = dvd_n;
      cnt_d  = CNT_W'(1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d  = rem_n;
      dvd_d  = dvd_n;
      cnt_d  = cnt_q + CNT_W'(1);
      if (cnt_q == '1) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      dvd_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      dvd_q  <= dvd_d;
      busy_q <= busy_d;
    end
  end

  assign busy          = busy_q;
  assign last          = busy_q && (cnt_q == '1);
  assign quotient_next = dvd_n;
`ifdef LCM_CHECK_EN
  assign remainder_next = rem_n;
`endif

endmodule

// File: rtl/lcm_unit.sv
// lcm_unit: lcm = x*y/g from a precomputed gcd g, via a multiply step and a bit-serial divide.
// Build option LCM_CHECK_EN flags err when g does not divide x*y.
module lcm_unit
  import lcm_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   x,
  input  logic [OP_W-1:0]   y,
  input  logic [OP_W-1:0]   g,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] lcm,
  output logic              err
);

  state_e             state_q, state_d;
  logic [OP_W-1:0]    x_q, x_d;
  logic [OP_W-1:0]    y_q, y_d;
  logic [OP_W-1:0]    g_q, g_d;
  logic [PROD_W-1:0]  p_q, p_d;
  logic [PROD_W-1:0]  lcm_q, lcm_d;
  logic               err_q, err_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic               div_start;
  logic               div_busy;
  logic               div_last;
  logic [PROD_W-1:0]  div_quot;
`ifdef LCM_CHECK_EN
  logic [REM_W-1:0]   div_rem;
`endif

  assign div_start = (state_q == DIV) && !div_busy;

  lcm_div8 u_div (
    .clk           (clk),
    .clr           (clr),
    .start         (div_start),
    .dividend      (p_q),
    .divisor       (g_q),
    .busy          (div_busy),
    .last          (div_last),
`ifdef LCM_CHECK_EN
    .remainder_next(div_rem),
`endif
    .quotient_next (div_quot)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    g_d     = g_q;
    p_d     = p_q;
    lcm_d   = lcm_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          x_d     = x;
          y_d     = y;
          g_d     = g;
          state_d = MUL;
        end
      end
      MUL: begin
        p_d = PROD_W'(x_q) * PROD_W'(y_q);
        if ((x_q == '0) || (y_q == '0) || (g_q == '0)) begin
          lcm_d   = '0;
          err_d   = (g_q == '0) && (x_q != '0) && (y_q != '0);
          state_d = DONE;
        end else begin
          err_d   = 1'b0;
          state_d = DIV;
        end
      end
      DIV: begin
        if (div_last) begin
          lcm_d   = div_quot;
`ifdef LCM_CHECK_EN
          err_d   = (div_rem != '0);
`else
          err_d   = 1'b0;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // out_valid rises one cycle after entering DONE and drops on the handshake edge.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_q == DONE) && !(out_valid_q && out_ready);
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      g_q         <= '0;
      p_q         <= '0;
      lcm_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      g_q         <= g_d;
      p_q         <= p_d;
      lcm_q       <= lcm_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign lcm       = lcm_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lcm_unit.sv
// Scoreboard testbench for lcm_unit; expected err for non-divisors follows LCM_CHECK_EN.
module tb_lcm_unit;

  logic       clk = 1'b0;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] x, y, g;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] lcm;
  logic       err;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [7:0] lcm;
    logic       err;
    int         lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  lcm_unit dut (
    .clk      (clk),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .y        (y),
    .g        (g),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .lcm      (lcm),
    .err      (err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int gcdOf(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic exp_t modelOf(input int ax, input int ay, input int ag);
    exp_t e;
    int p;
    p = ax * ay;
    if (ax == 0 || ay == 0 || ag == 0) begin
      e.lcm = 8'd0;
      e.err = (ag == 0) && (ax != 0) && (ay != 0);
      e.lat = 2;
    end else begin
      e.lcm = 8'(p / ag);
`ifdef LCM_CHECK_EN
      e.err = (p % ag) != 0;
`else
      e.err = 1'b0;
`endif
      e.lat = 10;
    end
    return e;
  endfunction

  task automatic driveAccept(input logic [3:0] ax, input logic [3:0] ay, input logic [3:0] ag);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("in_ready_before_accept", in_ready, 1);
    x = ax;
    y = ay;
    g = ag;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [3:0] ax, input logic [3:0] ay, input logic [3:0] ag,
                               input int hold, input bit noise);
    exp_t e;
    int lat;
    logic [7:0] held_lcm;
    logic held_err;
    sb.push_back(modelOf(int'(ax), int'(ay), int'(ag)));
    driveAccept(ax, ay, ag);
    lat = 0;
    while (lat < 40) begin
      if (noise) begin
        in_valid = 1'b1;
        x = 4'($urandom);
        y = 4'($urandom);
        g = 4'($urandom);
      end
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
      checkOutput("in_ready_busy", in_ready, 0);
    end
    in_valid = 1'b0;
    checkOutput("out_valid_seen", out_valid, 1);
    if (sb.size() == 0) begin
      checkOutput("scoreboard_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      checkOutput("latency", lat, e.lat);
      checkOutput("lcm", lcm, e.lcm);
      checkOutput("err", err, e.err);
    end
    held_lcm = lcm;
    held_err = err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_out_valid", out_valid, 1);
      checkOutput("hold_lcm", lcm, held_lcm);
      checkOutput("hold_err", err, held_err);
      checkOutput("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("release_out_valid", out_valid, 0);
    checkOutput("release_in_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0] a, b;
    clr       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x = '0;
    y = '0;
    g = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_lcm", lcm, 0);
    checkOutput("reset_err", err, 0);
    clr = 1'b1;
    @(posedge clk); #1;

    applyStimulus(4'd3, 4'd6, 4'd3, 0, 1'b0);
    applyStimulus(4'd4, 4'd8, 4'd4, 0, 1'b1);
    applyStimulus(4'd15, 4'd14, 4'd1, 0, 1'b0);
    applyStimulus(4'd0, 4'd5, 4'd5, 0, 1'b0);
    applyStimulus(4'd6, 4'd4, 4'd2, 5, 1'b0);
    applyStimulus(4'd3, 4'd4, 4'd0, 2, 1'b0);

    // Abort an operation in its fourth divide cycle.
    driveAccept(4'd7, 4'd9, 4'd3);
    repeat (4) @(posedge clk);
    #1;
    clr = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_lcm", lcm, 0);
    checkOutput("midreset_err", err, 0);
    checkOutput("midreset_in_ready", in_ready, 1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      checkOutput("midreset_quiet", out_valid, 0);
    end
    applyStimulus(4'd5, 4'd10, 4'd5, 0, 1'b0);

    applyStimulus(4'd5, 4'd7, 4'd2, 1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      a = 4'($urandom_range(15, 1));
      b = 4'($urandom_range(15, 1));
      applyStimulus(a, b, 4'(gcdOf(int'(a), int'(b))), (i % 2) * 2, (i % 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
